// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: access sizes, fault causes, FSM states.
// Latency: none (constants, types and one combinational helper).
// Backpressure: not applicable.
package mem_access_pkg;

  // Access size encodings carried on ex_size
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  // Exception causes raised by this stage
  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_LD_FAULT    = 5'd5;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_ST_FAULT    = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte-enable pattern of an access of the given size, anchored at lane 0
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = 8'h01;
      SZ_HALF: size_mask = 8'h03;
      SZ_WORD: size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: misalign detect, store shift + byte mask, load shift + extension.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_lo/size/is_unsigned describe the access; st_data is raw store data,
//        rd_data the aligned 64-bit bus word; outputs are lane-adjusted.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int unsigned MASK_UNUSED = 1
) (
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] st_data,
  input  logic [63:0] rd_data,
  output logic        misaligned,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] ld_data
);

  logic [5:0]  lane;
  logic [63:0] rd_shift;
  logic        sx;

  always_comb begin
    lane = {addr_lo, 3'b000};

    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo[1:0];
      default: misaligned = |addr_lo;
    endcase

    wdata = st_data << lane;
    wmask = (MASK_UNUSED != 0) ? (size_mask(size) << addr_lo) : 8'hFF;

    rd_shift = rd_data >> lane;
    sx       = ~is_unsigned;
    case (size)
      SZ_BYTE: ld_data = {{56{rd_shift[7]  & sx}}, rd_shift[7:0]};
      SZ_HALF: ld_data = {{48{rd_shift[15] & sx}}, rd_shift[15:0]};
      SZ_WORD: ld_data = {{32{rd_shift[31] & sx}}, rd_shift[31:0]};
      default: ld_data = rd_shift;  // doubleword: nothing to extend
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one bus transaction per load/store, registered wb record.
// Latency: 1 cycle for non-memory/faulting ops; >= 4 cycles (accept, REQ, WAIT, DONE) for memory ops.
// Backpressure: stall holds execute while a transaction is pending; req waits on req_ready.
// Ports: ex_* from execute, req_*/rsp_* data-memory bus, wb_* registered record to writeback.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int          TIMEOUT     = 255,
  parameter int unsigned MASK_UNUSED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_result,
  input  logic [63:0] ex_data2,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic        ex_exc,
  input  logic [4:0]  ex_cause,
  input  logic [63:0] ex_tval,
  output logic        stall,
  output logic        req_valid,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wmask,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_exc,
  output logic [4:0]  wb_cause,
  output logic [63:0] wb_tval
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // Context of the in-flight memory op (execute has moved on by DONE)
  logic [63:0] pc_q, pc_d, addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d, st_q, st_d;
  logic        req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [63:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [7:0]  req_wmask_q, req_wmask_d;
  logic        wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;
  logic [63:0] wb_pc_q, wb_pc_d, wb_data_q, wb_data_d, wb_tval_q, wb_tval_d;
  logic [4:0]  wb_rd_q, wb_rd_d, wb_cause_q, wb_cause_d;

  logic        is_mem, mem_go, use_ex;
  logic [2:0]  al_addr;
  logic [1:0]  al_size;
  logic        al_uns, al_misaligned;
  logic [63:0] al_wdata, al_ld_data;
  logic [7:0]  al_wmask;

  // Aligner sees the live execute op while idle and the captured op afterwards
  always_comb begin
    use_ex  = (state_q == ST_IDLE);
    al_addr = use_ex ? ex_result[2:0] : addr_q[2:0];
    al_size = use_ex ? ex_size        : size_q;
    al_uns  = use_ex ? ex_unsigned    : uns_q;
  end

  mem_align #(.MASK_UNUSED(MASK_UNUSED)) u_align (
    .addr_lo     (al_addr),
    .size        (al_size),
    .is_unsigned (al_uns),
    .st_data     (ex_data2),
    .rd_data     (rsp_rdata),
    .misaligned  (al_misaligned),
    .wdata       (al_wdata),
    .wmask       (al_wmask),
    .ld_data     (al_ld_data)
  );

  always_comb begin
    is_mem = ex_load | ex_store;
    mem_go = (state_q == ST_IDLE) && ex_valid && is_mem && !ex_exc && !al_misaligned;
    stall  = (state_q == ST_REQ) || (state_q == ST_WAIT) || mem_go;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    size_d      = size_q;
    uns_d       = uns_q;
    st_d        = st_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    wb_valid_d  = 1'b0;
    wb_pc_d     = wb_pc_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_exc_d    = wb_exc_q;
    wb_cause_d  = wb_cause_q;
    wb_tval_d   = wb_tval_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!is_mem || ex_exc) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = ex_pc;
            wb_rd_d    = ex_exc ? 5'd0 : ex_rd;
            wb_data_d  = ex_result;
            wb_exc_d   = ex_exc;
            wb_cause_d = ex_exc ? ex_cause : 5'd0;
            wb_tval_d  = ex_exc ? ex_tval : 64'd0;
          end else if (al_misaligned) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = ex_pc;
            wb_rd_d    = 5'd0;
            wb_data_d  = 64'd0;
            wb_exc_d   = 1'b1;
            wb_cause_d = ex_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            wb_tval_d  = ex_result;
          end else begin
            state_d     = ST_REQ;
            pc_d        = ex_pc;
            addr_d      = ex_result;
            rd_d        = ex_rd;
            size_d      = ex_size;
            uns_d       = ex_unsigned;
            st_d        = ex_store;  // load+store together behaves as a store
            req_valid_d = 1'b1;
            req_we_d    = ex_store;
            req_addr_d  = {ex_result[63:3], 3'b000};
            req_wdata_d = ex_store ? al_wdata : 64'd0;
            req_wmask_d = ex_store ? al_wmask : 8'd0;
          end
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
          cnt_d       = 16'd0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response arriving on the deadline cycle is still accepted
        if (rsp_valid) begin
          state_d    = ST_DONE;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_rd_d    = st_q ? 5'd0 : rd_q;
          wb_data_d  = st_q ? 64'd0 : al_ld_data;
          wb_exc_d   = 1'b0;
          wb_cause_d = 5'd0;
          wb_tval_d  = 64'd0;
        end else if (cnt_d == TIMEOUT_CNT) begin
          state_d    = ST_DONE;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_rd_d    = 5'd0;
          wb_data_d  = 64'd0;
          wb_exc_d   = 1'b1;
          wb_cause_d = st_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          wb_tval_d  = addr_q;
        end
      end
      default: state_d = ST_IDLE;  // DONE: execute advances this cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      st_q        <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_exc_q    <= 1'b0;
      wb_cause_q  <= '0;
      wb_tval_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      st_q        <= st_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_exc_q    <= wb_exc_d;
      wb_cause_q  <= wb_cause_d;
      wb_tval_q   <= wb_tval_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_wmask = req_wmask_q;
  assign wb_valid  = wb_valid_q;
  assign wb_pc     = wb_pc_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_exc    = wb_exc_q;
  assign wb_cause  = wb_cause_q;
  assign wb_tval   = wb_tval_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execute. Consumes the execute result, store data and load/store ops.
- Performs one data-memory transaction per load/store over a valid/ready request and response bus. Sign- or zero-extends load data.
- Detects misaligned addresses and bus timeouts. Forwards one registered record per instruction to writeback.
- Stalls execute while a transaction is outstanding.

Parameters:
- TIMEOUT, 255, max cycles from request acceptance to response before access fault (1..65535)
- MASK_UNUSED, 1, when 1, wmask bytes outside the access are forced to 0

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  execute presents an instruction this cycle
- ex_pc  input  64  instruction pc
- ex_rd  input  5  destination register index
- ex_result  input  64  ALU result; effective address for load/store
- ex_data2  input  64  store data
- ex_load  input  1  load op
- ex_store  input  1  store op
- ex_size  input  2  0=byte 1=half 2=word 3=double
- ex_unsigned  input  1  zero-extend load
- ex_exc  input  1  upstream exception present
- ex_cause  input  5  upstream cause
- ex_tval  input  64  upstream tval
- stall  output  1  hold execute; ex_* must stay stable while high
- req_valid  output  1  bus request
- req_we  output  1  1=store
- req_addr  output  64  8-byte-aligned address
- req_wdata  output  64  store data shifted to byte lane
- req_wmask  output  8  byte enables
- req_ready  input  1  bus accepts request
- rsp_valid  input  1  bus response
- rsp_rdata  input  64  aligned 64-bit read data
- wb_valid  output  1  record valid (one cycle per instruction)
- wb_pc  output  64  pc
- wb_rd  output  5  rd; 0 on exception
- wb_data  output  64  load data or ex_result
- wb_exc  output  1  exception
- wb_cause  output  5  cause
- wb_tval  output  64  faulting address or upstream tval

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-transaction abandons it; no wb record.
- FSM states:
  - IDLE: accept ex_valid.
    - Non-memory op, or ex_exc: register into wb next cycle, no stall (latency 1).
    - Misaligned (addr[size-1:0]≠0): wb next cycle, exc=1, cause 4 for a load / 6 for a store, tval=addr, no bus access.
    - Aligned load/store: go to REQ. stall is asserted combinationally in that same cycle.
  - REQ: req_valid=1 and stays stable until req_ready.
    - On req_valid&&req_ready, go to WAIT and clear the counter.
    - Request wait time is not counted toward the timeout.
  - WAIT: counter increments each cycle.
    - rsp_valid: go to DONE with data captured.
    - Counter==TIMEOUT with no rsp_valid: go to DONE, fault cause 5 for a load / 7 for a store, tval=addr.
    - rsp_valid in the same cycle as TIMEOUT: the response wins.
  - DONE: wb_valid=1 for one cycle, stall low. Return to IDLE.
    - In the DONE cycle, execute advances; the next ex_valid is accepted in the following cycle.
- stall = (state≠IDLE&&state≠DONE) || (IDLE && ex_valid && aligned mem op && !ex_exc).
- Minimum memory latency: IDLE→REQ→WAIT→DONE with ready and response immediate, i.e. 4 cycles including accept.
- Load extraction:
  - Lane = addr[2:0]×8, shift rsp_rdata right by the lane.
  - Sign-extend bit 8·2^size−1 unless ex_unsigned; size 3 ignores ex_unsigned.
- Store:
  - wdata = data2 << lane.
  - wmask = ((1<<2^size)−1) << addr[2:0].
  - req_addr = {addr[63:3],3'b0}.
- Both ex_load and ex_store high is treated as a store.
- rsp_valid outside WAIT is ignored.
- Stores write wb_rd=0 and wb_data=0.

Decomposition:
- Shared package (isa pkg): size encodings; cause constants CAUSE_LD_MISALIGN=4, CAUSE_LD_FAULT=5, CAUSE_ST_MISALIGN=6, CAUSE_ST_FAULT=7; FSM state enum.
- One sub-module mem_align (combinational): lane shift, wmask generation, load extension, misalign detect.

Test Plan:
- Non-memory op, pc=0x80000000, rd=5, result=0x1234 -> wb_valid next cycle, wb_data=0x1234, stall never high.
- lb, addr=0x1003, rsp_rdata=0x00000000_80FF7F00, ready and response immediate -> req_addr=0x1000, wb_data=0xFFFFFFFFFFFFFF80 after 4 cycles; lbu gives 0x80.
- sh, addr=0x2006, data2=0xBEEF -> req_we=1, wmask=0xC0, wdata=0xBEEF000000000000, wb_rd=0, wb_exc=0.
- lw, addr=0x3002 -> no req_valid; wb_exc=1, cause=4, tval=0x3002 next cycle.
- ld with req_ready low 10 cycles, then accepted, no response (TIMEOUT=8) -> wb cause=5 exactly 8 cycles after acceptance; repeat with rsp_valid on cycle 8 -> data returned, no exception.
- rst_n pulsed low while in WAIT -> all outputs 0, stall 0; a later rsp_valid is ignored and produces no wb record.
